// File: rtl/control_ranas_param.sv
// Frog-sequence controller: launches N_RANAS frogs in turn, tracks lives and a
// per-frog time limit, and reports win / game-over / timeout pulses.
module control_ranas_param #(
    parameter int                            DATAWIDTH_ESTADO = 3,
    parameter logic [DATAWIDTH_ESTADO-1:0]   ESTADO_INICIO    = 3'b111,
    parameter int                            N_RANAS          = 3,
    parameter int                            N_VIDAS          = 3,
    parameter int                            T_LIMITE         = 1000,
    parameter int                            W_RANAS          = 2,
    parameter int                            W_VIDAS          = 2,
    parameter int                            W_TIEMPO         = 10
) (
    input  logic                         CR_CLOCK_50,
    input  logic                         CR_RESET,
    input  logic [DATAWIDTH_ESTADO-1:0]  CR_ESTADO,
    input  logic                         CR_GANO,
    input  logic                         CR_PERDIO,
    output logic                         CR_RANA_INI_OUT,
    output logic                         CR_GANO_JC_OUT,
    output logic                         CR_PERDIO_JC_OUT,
    output logic                         CR_TIMEOUT_OUT,
    output logic [W_RANAS-1:0]           CR_RANAS_OUT,
    output logic [W_VIDAS-1:0]           CR_VIDAS_OUT,
    output logic [W_TIEMPO-1:0]          CR_TIEMPO_OUT,
    output logic [2:0]                   CR_FASE_OUT
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        INIT = 3'b001,
        PLAY = 3'b010,
        WIN  = 3'b011,
        OVER = 3'b100
    } fase_t;

    localparam logic [W_RANAS-1:0]  RANAS_META  = W_RANAS'(N_RANAS);
    localparam logic [W_VIDAS-1:0]  VIDAS_INI   = W_VIDAS'(N_VIDAS);
    localparam logic [W_VIDAS-1:0]  VIDAS_UNA   = W_VIDAS'(1);
    localparam logic [W_TIEMPO-1:0] TIEMPO_MAX  = W_TIEMPO'(T_LIMITE - 1);
    localparam logic [W_RANAS-1:0]  RANAS_UNA   = W_RANAS'(1);
    localparam logic [W_TIEMPO-1:0] TIEMPO_UNO  = W_TIEMPO'(1);

    fase_t                state_reg, state_next;
    logic [W_RANAS-1:0]   ranas_reg, ranas_next;
    logic [W_VIDAS-1:0]   vidas_reg, vidas_next;
    logic [W_TIEMPO-1:0]  tiempo_reg, tiempo_next;
    logic                 timeout_reg, timeout_next;

    logic                 expira;
    logic [W_RANAS-1:0]   ranas_inc;

    // Timeout only counts when neither frog event is present this cycle.
    assign expira    = !CR_GANO && !CR_PERDIO && (tiempo_reg == TIEMPO_MAX);
    assign ranas_inc = ranas_reg + RANAS_UNA;

    always_ff @(posedge CR_CLOCK_50 or posedge CR_RESET) begin
        if (CR_RESET) begin
            state_reg   <= IDLE;
            ranas_reg   <= '0;
            vidas_reg   <= VIDAS_INI;
            tiempo_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ranas_reg   <= ranas_next;
            vidas_reg   <= vidas_next;
            tiempo_reg  <= tiempo_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ranas_next   = ranas_reg;
        vidas_next   = vidas_reg;
        tiempo_next  = tiempo_reg;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (CR_ESTADO == ESTADO_INICIO) begin
                    state_next  = INIT;
                    ranas_next  = '0;
                    vidas_next  = VIDAS_INI;
                    tiempo_next = '0;
                end
            end
            INIT: begin
                tiempo_next = '0;
                state_next  = PLAY;
            end
            PLAY: begin
                if (CR_GANO) begin
                    ranas_next = ranas_inc;
                    state_next = (ranas_inc == RANAS_META) ? WIN : INIT;
                end else if (CR_PERDIO || expira) begin
                    timeout_next = expira;
                    if (vidas_reg > VIDAS_UNA) begin
                        vidas_next = vidas_reg - VIDAS_UNA;
                        state_next = INIT;
                    end else begin
                        vidas_next = '0;
                        state_next = OVER;
                    end
                end else begin
                    // Timer holds on the exit cycle so it never reaches T_LIMITE.
                    tiempo_next = tiempo_reg + TIEMPO_UNO;
                end
            end
            WIN:     state_next = IDLE;
            OVER:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign CR_RANA_INI_OUT  = (state_reg == IDLE) || (state_reg == INIT);
    assign CR_GANO_JC_OUT   = (state_reg == WIN);
    assign CR_PERDIO_JC_OUT = (state_reg == OVER);
    assign CR_TIMEOUT_OUT   = timeout_reg;
    assign CR_RANAS_OUT     = ranas_reg;
    assign CR_VIDAS_OUT     = vidas_reg;
    assign CR_TIEMPO_OUT    = tiempo_reg;
    assign CR_FASE_OUT      = state_reg;

endmodule

// File: tb/tb_control_ranas_param.sv
// Scoreboard bench for control_ranas_param: directed game scenarios followed by
// randomized play, checked against a game-rule model kept in the bench.
module tb_control_ranas_param;

    localparam int NR = 3;
    localparam int NV = 2;
    localparam int TL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] estado = 3'b000;
    logic       gano = 1'b0;
    logic       perdio = 1'b0;
    logic       rana_ini, gano_jc, perdio_jc, timeout;
    logic [1:0] ranas, vidas;
    logic [9:0] tiempo;
    logic [2:0] fase;

    control_ranas_param #(
        .DATAWIDTH_ESTADO (3),
        .ESTADO_INICIO    (3'b111),
        .N_RANAS          (NR),
        .N_VIDAS          (NV),
        .T_LIMITE         (TL),
        .W_RANAS          (2),
        .W_VIDAS          (2),
        .W_TIEMPO         (10)
    ) dut (
        .CR_CLOCK_50      (clk),
        .CR_RESET         (rst),
        .CR_ESTADO        (estado),
        .CR_GANO          (gano),
        .CR_PERDIO        (perdio),
        .CR_RANA_INI_OUT  (rana_ini),
        .CR_GANO_JC_OUT   (gano_jc),
        .CR_PERDIO_JC_OUT (perdio_jc),
        .CR_TIMEOUT_OUT   (timeout),
        .CR_RANAS_OUT     (ranas),
        .CR_VIDAS_OUT     (vidas),
        .CR_TIEMPO_OUT    (tiempo),
        .CR_FASE_OUT      (fase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fase;
        int ranas;
        int vidas;
        int tiempo;
        int to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: phase names as plain integers 0 idle,1 launch,2 play,3 win,4 over.
    int m_fase, m_ranas, m_vidas, m_tiempo, m_to;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_fase = 0; m_ranas = 0; m_vidas = NV; m_tiempo = 0; m_to = 0;
    endtask

    task automatic model_step(input int e, input int g, input int p);
        m_to = 0;
        case (m_fase)
            0: if (e == 7) begin
                   m_fase = 1; m_ranas = 0; m_vidas = NV; m_tiempo = 0;
               end
            1: begin m_tiempo = 0; m_fase = 2; end
            2: begin
                if (g != 0) begin
                    m_ranas = m_ranas + 1;
                    m_fase  = (m_ranas == NR) ? 3 : 1;
                end else if (p != 0 || m_tiempo == TL - 1) begin
                    m_to    = (p == 0) ? 1 : 0;
                    m_vidas = m_vidas - 1;
                    m_fase  = (m_vidas == 0) ? 4 : 1;
                end else begin
                    m_tiempo = m_tiempo + 1;
                end
            end
            default: m_fase = 0;
        endcase
    endtask

    function automatic exp_t snap();
        exp_t x;
        x.fase = m_fase; x.ranas = m_ranas; x.vidas = m_vidas;
        x.tiempo = m_tiempo; x.to = m_to;
        return x;
    endfunction

    task automatic cycle(input int e, input int g, input int p);
        @(negedge clk);
        rst    = 1'b0;
        estado = 3'(e);
        gano   = (g != 0);
        perdio = (p != 0);
        model_step(e, g, p);
        q.push_back(snap());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; estado = 3'b000; gano = 1'b0; perdio = 1'b0;
        #1;
        // Asynchronous: values must already be cleared before any clock edge.
        chk("rst_fase", int'(fase), 0);
        chk("rst_ranas", int'(ranas), 0);
        chk("rst_vidas", int'(vidas), NV);
        chk("rst_tiempo", int'(tiempo), 0);
        chk("rst_pulses", int'({gano_jc, perdio_jc, timeout}), 0);
        chk("rst_ini", int'(rana_ini), 1);
        model_reset();
        q.push_back(snap());
    endtask

    task automatic run_to_play();
        int n = 0;
        while (m_fase != 2 && n < 20) begin
            cycle(0, 0, 0);
            n++;
        end
        checks++;
        if (m_fase != 2) begin
            errors++;
            $display("FAIL run_to_play actual_phase=%0d required=2", m_fase);
        end
    endtask

    task automatic run_to_idle();
        int n = 0;
        while (m_fase != 0 && n < 40) begin
            cycle(0, 0, 0);
            n++;
        end
        checks++;
        if (m_fase != 0) begin
            errors++;
            $display("FAIL run_to_idle actual_phase=%0d required=0", m_fase);
        end
    endtask

    // Monitor: every clock the DUT presents a full output set; compare it to the next expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("fase", int'(fase), x.fase);
                chk("ranas", int'(ranas), x.ranas);
                chk("vidas", int'(vidas), x.vidas);
                chk("tiempo", int'(tiempo), x.tiempo);
                chk("timeout", int'(timeout), x.to);
                chk("rana_ini", int'(rana_ini), (x.fase <= 1) ? 1 : 0);
                chk("gano_jc", int'(gano_jc), (x.fase == 3) ? 1 : 0);
                chk("perdio_jc", int'(perdio_jc), (x.fase == 4) ? 1 : 0);
                $display("txn t=%0t fase=%0d ranas=%0d vidas=%0d tiempo=%0d to=%0d",
                         $time, fase, ranas, vidas, tiempo, timeout);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Start and win with three frogs.
        cycle(7, 0, 0);
        cycle(0, 0, 0);
        for (int k = 0; k < NR; k++) begin
            run_to_play();
            cycle(0, 0, 0);
            cycle(0, 1, 0);
        end
        run_to_idle();
        cycle(0, 0, 0);

        // Two full timeouts end the game.
        cycle(7, 0, 0);
        run_to_play();
        for (int k = 0; k < TL; k++) cycle(0, 0, 0);
        run_to_play();
        for (int k = 0; k < TL; k++) cycle(0, 0, 0);
        run_to_idle();

        // Simultaneous win and loss counts as a win.
        cycle(7, 0, 0);
        run_to_play();
        cycle(0, 1, 1);
        run_to_play();

        // Reach ranas=2, vidas=1 then reset mid-play.
        cycle(0, 1, 0);
        run_to_play();
        cycle(0, 0, 1);
        run_to_play();
        cycle(0, 0, 0);
        do_reset();

        // Frog inputs in IDLE without the start code do nothing.
        for (int k = 0; k < 10; k++)
            cycle($urandom_range(0, 6), $urandom_range(0, 1), $urandom_range(0, 1));

        // Randomized play.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) == 0) ? 7 : $urandom_range(0, 6),
                      ($urandom_range(0, 9) == 0) ? 1 : 0,
                      ($urandom_range(0, 11) == 0) ? 1 : 0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
